// File: rtl/paddle_pkg.sv
// Shared constants, FSM state encoding and palette index type for the paddle sprite read path.
package paddle_pkg;

    localparam int SPRITE_W = 200;
    localparam int SPRITE_H = 150;
    localparam int ADDR_W   = 19;

    localparam logic [10:0] W11   = 11'(SPRITE_W);
    localparam logic [10:0] H11   = 11'(SPRITE_H);
    localparam logic [10:0] H_VIS = 11'd640;
    localparam logic [10:0] V_VIS = 11'd480;

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(SPRITE_W * SPRITE_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_SPAN,
        SPAN,
        POST_SPAN,
        DONE
    } state_t;

    typedef logic [1:0] pal_idx_t;

    // Displayed sprite extent after the depth shrink.
    function automatic logic [10:0] shrink(input logic [10:0] full, input logic [1:0] s);
        return full >> s;
    endfunction

endpackage

// File: rtl/sprite_palette.sv
// Palette lookup: maps a 2-bit sprite index to RGB, index 0 transparent.
// Latency: one pix_en strobe, output registered.
// No backpressure: updates on every strobe, holds between strobes.
module sprite_palette
    import paddle_pkg::*;
#(
    parameter logic [23:0] PAL1 = 24'hFFFFFF,
    parameter logic [23:0] PAL2 = 24'hFF0000,
    parameter logic [23:0] PAL3 = 24'h0000FF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        en,
    input  logic        vld,
    input  pal_idx_t    idx,
    output logic        opaque,
    output logic [23:0] rgb
);

    logic        opaque_q;
    logic [23:0] rgb_q;
    logic        opaque_d;
    logic [23:0] rgb_d;

    always_comb begin
        opaque_d = vld && (idx != 2'd0);
        rgb_d    = 24'h000000;
        if (opaque_d) begin
            case (idx)
                2'd1:    rgb_d = PAL1;
                2'd2:    rgb_d = PAL2;
                2'd3:    rgb_d = PAL3;
                default: rgb_d = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            opaque_q <= 1'b0;
            rgb_q    <= 24'h000000;
        end else if (en) begin
            opaque_q <= opaque_d;
            rgb_q    <= rgb_d;
        end
    end

    assign opaque = opaque_q;
    assign rgb    = rgb_q;

endmodule

// File: rtl/paddle_sprite_reader.sv
// Paddle sprite reader: raster-tracking RAM address generator plus palette mapping with depth scale.
// Latency: colour and DrawX_d/DrawY_d appear one pixel strobe after the raster position.
// No backpressure: raster-locked, state advances only on pix_en, RAM read every Clk.
module paddle_sprite_reader
    import paddle_pkg::*;
#(
    parameter logic [23:0] PAL1 = 24'hFFFFFF,
    parameter logic [23:0] PAL2 = 24'hFF0000,
    parameter logic [23:0] PAL3 = 24'h0000FF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PaddleX,
    input  logic [9:0]        PaddleY,
    input  logic [1:0]        scale,
    output logic [ADDR_W-1:0] read_address,
    input  logic [1:0]        ram_data,
    output logic              is_paddle,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic [9:0]        DrawX_d,
    output logic [9:0]        DrawY_d
);

    state_t            state_q;
    logic [9:0]        px_q, py_q;
    logic [1:0]        s_q;
    logic              armed_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] addr_q;
    logic              v0_q;
    logic [9:0]        dx_q, dy_q;
    logic [9:0]        dxd_q, dyd_q;

    logic              frame_start, line_start;
    logic [9:0]        px_e, py_e;
    logic [1:0]        s_e;
    logic [10:0]       x11, y11, px11, py11, dw, dh;
    logic              row_in, col_in, in_sprite, span_end;
    logic [ADDR_W-1:0] row_step, col_step, addr_inc, addr_d, row_base_d;
    logic [23:0]       rgb;

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign line_start  = (DrawX == 10'd0);

    // On the frame-start strobe, decisions use the values being latched this cycle.
    assign px_e = frame_start ? PaddleX : px_q;
    assign py_e = frame_start ? PaddleY : py_q;
    assign s_e  = frame_start ? scale   : s_q;

    assign x11  = {1'b0, DrawX};
    assign y11  = {1'b0, DrawY};
    assign px11 = {1'b0, px_e};
    assign py11 = {1'b0, py_e};
    assign dw   = shrink(W11, s_e);
    assign dh   = shrink(H11, s_e);

    assign row_in    = (y11 >= py11) && (y11 < py11 + dh) && (y11 < V_VIS) && (px11 < H_VIS);
    assign col_in    = (x11 >= px11) && (x11 < px11 + dw) && (x11 < H_VIS);
    assign in_sprite = (frame_start || armed_q) && row_in && col_in;
    assign span_end  = (x11 == px11 + dw - 11'd1) || (x11 == H_VIS - 11'd1);

    assign row_step   = ADDR_W'(W11) << s_q;
    assign col_step   = ADDR_W'(1) << s_q;
    assign addr_inc   = addr_q + col_step;
    assign addr_d     = (addr_inc > ADDR_MAX) ? ADDR_MAX : addr_inc;
    assign row_base_d = row_base_q + row_step;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            px_q       <= '0;
            py_q       <= '0;
            s_q        <= '0;
            armed_q    <= 1'b0;
            row_base_q <= '0;
            addr_q     <= '0;
            v0_q       <= 1'b0;
            dx_q       <= '0;
            dy_q       <= '0;
            dxd_q      <= '0;
            dyd_q      <= '0;
        end else if (pix_en) begin
            v0_q  <= in_sprite;
            dx_q  <= DrawX;
            dy_q  <= DrawY;
            dxd_q <= dx_q;
            dyd_q <= dy_q;
            if (frame_start) begin
                px_q       <= PaddleX;
                py_q       <= PaddleY;
                s_q        <= scale;
                armed_q    <= 1'b1;
                row_base_q <= '0;
                if (!row_in) begin
                    state_q <= IDLE;
                end else if (px_e == 10'd0) begin
                    state_q <= SPAN;
                    addr_q  <= '0;
                end else begin
                    state_q <= PRE_SPAN;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // Stays here after a reset until a frame start re-arms the block.
                        if (armed_q && line_start && row_in) begin
                            if (px_e == 10'd0) begin
                                state_q <= SPAN;
                                addr_q  <= row_base_q;
                            end else begin
                                state_q <= PRE_SPAN;
                            end
                        end
                    end
                    PRE_SPAN: begin
                        if (DrawX == px_q) begin
                            state_q <= SPAN;
                            addr_q  <= row_base_q;
                        end
                    end
                    SPAN: begin
                        addr_q <= addr_d;
                        if (span_end) begin
                            state_q <= POST_SPAN;
                        end
                    end
                    POST_SPAN: begin
                        if (line_start) begin
                            if (!row_in) begin
                                state_q <= DONE;
                            end else begin
                                row_base_q <= row_base_d;
                                if (px_q == 10'd0) begin
                                    state_q <= SPAN;
                                    addr_q  <= row_base_d;
                                end else begin
                                    state_q <= PRE_SPAN;
                                end
                            end
                        end
                    end
                    DONE: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    sprite_palette #(
        .PAL1(PAL1),
        .PAL2(PAL2),
        .PAL3(PAL3)
    ) u_palette (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .en     (pix_en),
        .vld    (v0_q),
        .idx    (ram_data),
        .opaque (is_paddle),
        .rgb    (rgb)
    );

    assign read_address = addr_q;
    assign Red          = rgb[23:16];
    assign Green        = rgb[15:8];
    assign Blue         = rgb[7:0];
    assign DrawX_d      = dxd_q;
    assign DrawY_d      = dyd_q;

endmodule

// File: doc/paddle_sprite_reader.md
Name: paddle_sprite_reader

Overview:
Read-side engine for the paddle sprite RAM. It tracks the VGA raster (DrawX/DrawY), generates the sprite RAM read address for the paddle, and absorbs the RAM's 1-cycle registered read latency. It maps the returned 2-bit palette index to RGB, with a per-frame depth scale for the 3D effect. It sits between the VGA controller, the paddle RAM read port and the colour mapper.

Parameters:
SPRITE_W, 200, sprite width in texels
SPRITE_H, 150, sprite height in texels (W*H = 30000 RAM words)
ADDR_W, 19, RAM address width
PAL1, 24'hFFFFFF, RGB for index 1
PAL2, 24'hFF0000, RGB for index 2
PAL3, 24'h0000FF, RGB for index 3

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous, active-low reset
pix_en  in  1  pixel strobe; asserted exactly every 2nd Clk (25 MHz pixel rate)
DrawX  in  10  current raster column, 0..799
DrawY  in  10  current raster row, 0..524
PaddleX  in  10  sprite top-left x
PaddleY  in  10  sprite top-left y
scale  in  2  depth shrink s; displayed size is (W>>s, H>>s)
read_address  out  ADDR_W  to RAM read_address
ram_data  in  2  from RAM data_Out; valid 1 Clk after read_address
is_paddle  out  1  pixel is opaque paddle
Red/Green/Blue  out  8 each  pixel colour; 0 when is_paddle=0
DrawX_d/DrawY_d  out  10 each  raster coordinates aligned with the colour outputs

Behaviour:
- Reset (async, Reset_n=0): all outputs 0, state IDLE, internal counters and latches 0. Deassertion is used synchronously. Reset mid-frame: the block idles until the next frame start.
- All state advances only on Clk edges with pix_en=1. read_address holds between strobes, and the RAM reads every Clk.
- Frame start (strobe with DrawX=0, DrawY=0):
  - latch PaddleX, PaddleY and scale into px, py, s
  - row_base=0
  - mid-frame changes to these inputs are ignored
- Displayed extent: dw=W>>s, dh=H>>s. A pixel is in-sprite iff px<=DrawX<px+dw, py<=DrawY<py+dh, DrawX<640 and DrawY<480.
  - Compare in 11 bits to avoid wrap.
  - Sprite off the right/bottom edge is clipped, never wrapped.
- FSM:
  - IDLE -> PRE_SPAN at the line-start strobe (DrawX=0) with DrawY in rows.
  - PRE_SPAN -> SPAN when DrawX==px:
    - col_addr = row_base
    - read_address = row_base
  - SPAN:
    - col_addr += (1<<s) each strobe
    - -> POST_SPAN when DrawX==px+dw-1 or DrawX==639
  - POST_SPAN -> PRE_SPAN at the next line start:
    - row_base += (W<<s)
    - if that was the last row (DrawY==py+dh-1), -> DONE instead
  - DONE -> IDLE at frame start.
  - A frame start while in any state forces a reload and the IDLE/PRE_SPAN evaluation.
- Address bound: read_address never exceeds W*H-1. Outside SPAN it holds its last value, and its data is ignored.
- Pipeline, latency 1 pixel:
  - On strobe k, read_address and the in-sprite flag v0 are registered, and DrawX/DrawY are captured.
  - On strobe k+1:
    - is_paddle = v0 && ram_data!=0
    - RGB = palette[ram_data] when is_paddle, else 0
    - DrawX_d/DrawY_d = the coordinates captured on strobe k
- Index 0 is transparent.

Decomposition:
Shared package (paddle_pkg):
- SPRITE_W, SPRITE_H, ADDR_W
- screen constants H_VIS=640, V_VIS=480
- state enum {IDLE, PRE_SPAN, SPAN, POST_SPAN, DONE}
- palette index typedef logic[1:0]

One sub-module, sprite_palette: registered index->RGB lookup with the transparency flag.

Test Plan:
- Reset_n pulled low mid-SPAN -> all outputs 0 immediately. After release, no is_paddle until the next frame start; the next frame draws correctly.
- PaddleX=100, PaddleY=50, s=0, with the RAM model filled with address-derived indices:
  - at DrawY=50, DrawX=100 -> read_address=0
  - DrawX=299 -> read_address=199
  - DrawY=51, DrawX=100 -> read_address=200
  - DrawY=199, DrawX=299 -> read_address=29999
  - DrawY=200 -> is_paddle never asserts
- s=1, same position -> span is 100 px, address steps by 2 per pixel, row_base steps by 400. Last row is DrawY=124 with base 29600.
- PaddleX=560, s=0 -> pixels 560..639 drawn, no is_paddle at DrawX>=640. The next row starts at row_base+200.
- RAM index 0 at a texel -> is_paddle=0 with RGB=0. Index 2 -> is_paddle=1 with RGB=FF0000, one strobe after DrawX matches; DrawX_d equals the prior DrawX.
- PaddleY changed from 50 to 60 mid-frame -> the current frame keeps rows 50..199, and the next frame starts at row 60.
